// File: rtl/hdc_pkg.sv
// Shared HDC constants and the AM search state type, used by both the query
// (read) path and the training (write) path.
`ifndef DIM
`define DIM 1024
`endif
`ifndef CLS_NUM
`define CLS_NUM 10
`endif
`ifndef CLS_DW
`define CLS_DW 4
`endif

package hdc_pkg;
   localparam int DIM     = `DIM;
   localparam int CLS_NUM = `CLS_NUM;
   localparam int CLS_DW  = `CLS_DW;
   localparam int CHUNK_W = 64;
   localparam int NCH     = DIM / CHUNK_W;
   localparam int SIMI_W  = $clog2(DIM) + 1;
   localparam int PC_W    = $clog2(CHUNK_W) + 1;
   localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [2:0] {IDLE, RD, LAT, ACC, CMP, DONE} state_e;
endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of one CHUNK_W-bit slice.
module chunk_popcount
   import hdc_pkg::*;
#(
   parameter int W  = CHUNK_W,
   parameter int CW = $clog2(W) + 1
) (
   input  logic [W-1:0]  data_i,
   output logic [CW-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < W; i++) begin
         cnt_o = cnt_o + CW'(data_i[i]);
      end
   end

endmodule

// File: rtl/am_query.sv
// Sequential associative-memory search: reads every class row, accumulates
// Hamming similarity CHUNK_W bits per cycle, and reports the best class.
//
// state | meaning
// IDLE  | waiting for a query, q_ready high
// RD    | AM read strobe for row cls
// LAT   | AM read latency; row data captured, accumulator cleared
// ACC   | popcount one chunk per cycle, NCH cycles
// CMP   | update best match, advance to next class or finish
// DONE  | result presented until res_ready
module am_query
   import hdc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              q_valid,
   output logic              q_ready,
   input  logic [DIM-1:0]    q_hv,
   output logic              am_rd_en,
   output logic [CLS_DW-1:0] am_rd_addr,
   input  logic [DIM-1:0]    am_rd_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CLS_DW-1:0] res_class,
   output logic [SIMI_W-1:0] res_simi
);

   state_e              state_q, state_d;
   logic [DIM-1:0]      q_reg_q, q_reg_d;
   logic [DIM-1:0]      row_q, row_d;
   logic [CLS_DW-1:0]   cls_q, cls_d;
   logic [CH_W-1:0]     chunk_q, chunk_d;
   logic [SIMI_W-1:0]   acc_q, acc_d;
   logic [SIMI_W-1:0]   best_simi_q, best_simi_d;
   logic [CLS_DW-1:0]   best_cls_q, best_cls_d;
   logic [CHUNK_W-1:0]  pc_in;
   logic [PC_W-1:0]     pc_cnt;

   assign pc_in = ~(row_q[chunk_q*CHUNK_W +: CHUNK_W] ^ q_reg_q[chunk_q*CHUNK_W +: CHUNK_W]);

   chunk_popcount #(.W(CHUNK_W), .CW(PC_W)) u_pc (
      .data_i (pc_in),
      .cnt_o  (pc_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         q_reg_q     <= '0;
         row_q       <= '0;
         cls_q       <= '0;
         chunk_q     <= '0;
         acc_q       <= '0;
         best_simi_q <= '0;
         best_cls_q  <= '0;
      end else begin
         state_q     <= state_d;
         q_reg_q     <= q_reg_d;
         row_q       <= row_d;
         cls_q       <= cls_d;
         chunk_q     <= chunk_d;
         acc_q       <= acc_d;
         best_simi_q <= best_simi_d;
         best_cls_q  <= best_cls_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      q_reg_d     = q_reg_q;
      row_d       = row_q;
      cls_d       = cls_q;
      chunk_d     = chunk_q;
      acc_d       = acc_q;
      best_simi_d = best_simi_q;
      best_cls_d  = best_cls_q;
      q_ready     = 1'b0;
      am_rd_en    = 1'b0;
      am_rd_addr  = '0;
      res_valid   = 1'b0;
      res_class   = '0;
      res_simi    = '0;

      case (state_q)
         IDLE: begin
            q_ready = 1'b1;
            if (q_valid) begin
               q_reg_d     = q_hv;
               cls_d       = '0;
               best_simi_d = '0;
               best_cls_d  = '0;
               state_d     = RD;
            end
         end
         RD: begin
            am_rd_en   = 1'b1;
            am_rd_addr = cls_q;
            state_d    = LAT;
         end
         LAT: begin
            row_d   = am_rd_data;
            acc_d   = '0;
            chunk_d = '0;
            state_d = ACC;
         end
         ACC: begin
            acc_d   = acc_q + SIMI_W'(pc_cnt);
            chunk_d = chunk_q + 1'b1;
            if (chunk_q == CH_W'(NCH - 1)) state_d = CMP;
         end
         CMP: begin
            // class 0 always seeds the best; later ties keep the lower index
            if (cls_q == '0 || acc_q > best_simi_q) begin
               best_simi_d = acc_q;
               best_cls_d  = cls_q;
            end
            if (cls_q == CLS_DW'(CLS_NUM - 1)) begin
               state_d = DONE;
            end else begin
               cls_d   = cls_q + 1'b1;
               state_d = RD;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            res_class = best_cls_q;
            res_simi  = best_simi_q;
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_am_query.sv
// Self-checking bench for am_query: behavioural search model plus a
// per-cycle compare of all outputs, and literal checks on directed cases.
module tb_am_query;
   import hdc_pkg::*;

   localparam int PER     = NCH + 3;
   localparam int LAT_TOT = CLS_NUM * PER;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              q_valid = 1'b0;
   logic              q_ready;
   logic [DIM-1:0]    q_hv = '0;
   logic              am_rd_en;
   logic [CLS_DW-1:0] am_rd_addr;
   logic [DIM-1:0]    am_rd_data = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [CLS_DW-1:0] res_class;
   logic [SIMI_W-1:0] res_simi;

   logic [DIM-1:0] mem [CLS_NUM];

   int vectors = 0;
   int miscompares = 0;

   am_query dut (
      .clk        (clk),
      .rst        (rst),
      .q_valid    (q_valid),
      .q_ready    (q_ready),
      .q_hv       (q_hv),
      .am_rd_en   (am_rd_en),
      .am_rd_addr (am_rd_addr),
      .am_rd_data (am_rd_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_class  (res_class),
      .res_simi   (res_simi)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (am_rd_en) am_rd_data <= mem[am_rd_addr];
   end

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DIM-1:0] rand_hv();
      logic [DIM-1:0] v;
      for (int i = 0; i < DIM / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [DIM-1:0] mask(input int lo, input int n);
      logic [DIM-1:0] m;
      m = '0;
      for (int i = lo; i < lo + n; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Model: idle/busy with elapsed cycles since the accepting edge.
   logic m_busy = 1'b0;
   int   m_el = 0;
   int   m_cls = 0;
   int   m_simi = 0;

   always @(posedge clk or posedge rst) begin
      int bc, bs, s;
      if (rst) begin
         m_busy <= 1'b0;
         m_el   <= 0;
      end else if (!m_busy) begin
         if (q_valid) begin
            bc = 0;
            bs = -1;
            for (int c = 0; c < CLS_NUM; c++) begin
               s = DIM - $countones(mem[c] ^ q_hv);
               if (s > bs) begin
                  bs = s;
                  bc = c;
               end
            end
            m_busy <= 1'b1;
            m_el   <= 0;
            m_cls  <= bc;
            m_simi <= bs;
         end
      end else if (m_el >= LAT_TOT && res_ready) begin
         m_busy <= 1'b0;
      end else if (m_el < LAT_TOT) begin
         m_el <= m_el + 1;
      end
   end

   always @(negedge clk) begin
      int e_rdy, e_val, e_en, e_addr, e_cls, e_simi;
      e_rdy = 0; e_val = 0; e_en = 0; e_addr = 0; e_cls = 0; e_simi = 0;
      if (rst || !m_busy) begin
         e_rdy = 1;
      end else if (m_el < LAT_TOT) begin
         e_en   = (m_el % PER == 0) ? 1 : 0;
         e_addr = e_en ? m_el / PER : 0;
      end else begin
         e_val  = 1;
         e_cls  = m_cls;
         e_simi = m_simi;
      end
      chk("q_ready", q_ready, e_rdy);
      chk("res_valid", res_valid, e_val);
      chk("am_rd_en", am_rd_en, e_en);
      chk("am_rd_addr", am_rd_addr, e_addr);
      chk("res_class", res_class, e_cls);
      chk("res_simi", res_simi, e_simi);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a query, wait for the result, hold backpressure, then handshake.
   task automatic run_query(input logic [DIM-1:0] hv, input int hold,
                            input bit pulse, output int lat);
      q_hv    = hv;
      q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      q_hv    = rand_hv();
      lat = 0;
      while (!res_valid && lat < 400) begin
         step();
         lat++;
      end
      if (!res_valid) chk("result_timeout", 0, 1);
      for (int i = 0; i < hold; i++) begin
         q_valid = (pulse && i == 5);
         step();
      end
      q_valid   = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   initial begin
      logic [DIM-1:0] q;
      int lat;

      for (int c = 0; c < CLS_NUM; c++) mem[c] = rand_hv();
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_q_ready", q_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_am_rd_en", am_rd_en, 0);
      chk("rst_res_class", res_class, 0);
      chk("rst_res_simi", res_simi, 0);

      // Exact match at row 3, with backpressure and ignored q_valid pulse
      q = rand_hv();
      for (int c = 0; c < CLS_NUM; c++) mem[c] = rand_hv();
      mem[3] = q;
      q_hv = q;
      q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      q_hv = rand_hv();
      lat = 0;
      while (!res_valid && lat < 400) begin
         step();
         lat++;
      end
      chk("exact_latency", lat, 190);
      chk("exact_class", res_class, 3);
      chk("exact_simi", res_simi, 1024);
      for (int i = 0; i < 20; i++) begin
         q_valid = (i == 7);
         step();
      end
      q_valid = 1'b0;
      chk("bp_class", res_class, 3);
      chk("bp_simi", res_simi, 1024);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("bp_release_valid", res_valid, 0);
      chk("bp_release_ready", q_ready, 1);

      // Tie: rows 1 and 5 match, others anti-match
      q = rand_hv();
      for (int c = 0; c < CLS_NUM; c++) mem[c] = ~q;
      mem[1] = q;
      mem[5] = q;
      q_hv = q;
      q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 400) begin
         step();
         lat++;
      end
      chk("tie_class", res_class, 1);
      chk("tie_simi", res_simi, 1024);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;

      // All rows anti-match
      for (int c = 0; c < CLS_NUM; c++) mem[c] = ~q;
      run_query(q, 0, 1'b0, lat);
      chk("anti_latency", lat, 190);

      // Graded similarity
      q = rand_hv();
      for (int c = 0; c < CLS_NUM; c++) mem[c] = q ^ mask(0, 100 * c);
      q_hv = q ^ mask(974, 50);
      q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 400) begin
         step();
         lat++;
      end
      chk("graded_class", res_class, 0);
      chk("graded_simi", res_simi, 974);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;

      // Mid-search reset
      q = rand_hv();
      q_hv = q;
      q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      repeat (49) step();
      rst = 1'b1;
      #1;
      chk("midrst_q_ready", q_ready, 1);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_am_rd_en", am_rd_en, 0);
      chk("midrst_res_simi", res_simi, 0);
      step();
      step();
      rst = 1'b0;
      step();
      for (int c = 0; c < CLS_NUM; c++) mem[c] = rand_hv();
      mem[7] = q;
      q_hv = q;
      q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 400) begin
         step();
         lat++;
      end
      chk("postrst_latency", lat, 190);
      chk("postrst_class", res_class, 7);
      chk("postrst_simi", res_simi, 1024);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;

      // Randomized searches
      for (int t = 0; t < 8; t++) begin
         q = rand_hv();
         for (int c = 0; c < CLS_NUM; c++) begin
            mem[c] = q ^ (rand_hv() & rand_hv() & rand_hv());
         end
         if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, CLS_NUM - 1)] = q;
         repeat ($urandom_range(0, 3)) step();
         run_query(q, $urandom_range(0, 6), 1'b1, lat);
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
